// File: rtl/gate_vector_sequencer.sv
// Stimulus/response sequencer for a 2-input combinational gate.
// Walks {a,b} through 00,01,10,11, holds each vector HOLD_CYCLES cycles,
// samples y on the last hold cycle and scores it against TRUTH.
module gate_vector_sequencer #(
  parameter int         HOLD_CYCLES = 4,
  parameter logic [3:0] TRUTH       = 4'b0001
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic       y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_t     state_q, state_d;
  logic [1:0] vec_q, vec_d;
  logic [7:0] hold_q, hold_d;
  logic       a_q, a_d;
  logic       b_q, b_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [2:0] err_q, err_d;
  logic [3:0] fail_q, fail_d;

  // Error counter increment; only four vectors exist, so it never exceeds 4.
  function automatic logic [2:0] err_inc(input logic [2:0] cnt);
    return (cnt >= 3'd4) ? 3'd4 : cnt + 3'd1;
  endfunction

  // Next-state and result logic: start/clear, hold timing, sample and score.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    hold_d  = hold_q;
    a_d     = a_q;
    b_d     = b_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    err_d   = err_q;
    fail_d  = fail_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          vec_d   = 2'd0;
          hold_d  = 8'd0;
          a_d     = 1'b0;
          b_d     = 1'b0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          err_d   = 3'd0;
          fail_d  = 4'd0;
        end
      end
      RUN: begin
        if (hold_q == HOLD_LAST) begin
          hold_d = 8'd0;
          // Case inequality so an undriven or X output counts as a failure.
          if (y !== TRUTH[vec_q]) begin
            fail_d[vec_q] = 1'b1;
            err_d         = err_inc(err_q);
          end
          if (vec_q == 2'd3) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == 3'd0);
            a_d     = 1'b0;
            b_d     = 1'b0;
          end else begin
            // Next vector goes out on this same edge: no dead cycles.
            vec_d = vec_q + 2'd1;
            a_d   = vec_d[1];
            b_d   = vec_d[0];
          end
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= 2'd0;
      hold_q  <= 8'd0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 3'd0;
      fail_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      hold_q  <= hold_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_vec  = fail_q;

endmodule

// File: tb/tb_gate_vector_sequencer.sv
// Directed bench: two sequencers (HOLD_CYCLES=4 and 1) each driving a
// selectable gate model (NOR, constant 0, OR).
module tb_gate_vector_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start4 = 1'b0;
  logic       start1 = 1'b0;
  int         mode = 0;  // 0: NOR, 1: y stuck at 0, 2: OR

  logic       a4, b4, y4, busy4, done4, pass4;
  logic [2:0] err4;
  logic [3:0] fail4;
  logic       a1, b1, y1, busy1, done1, pass1;
  logic [2:0] err1;
  logic [3:0] fail1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign y4 = (mode == 0) ? ~(a4 | b4) : (mode == 1) ? 1'b0 : (a4 | b4);
  assign y1 = (mode == 0) ? ~(a1 | b1) : (mode == 1) ? 1'b0 : (a1 | b1);

  gate_vector_sequencer #(.HOLD_CYCLES(4), .TRUTH(4'b0001)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .y(y4),
    .busy(busy4), .done(done4), .pass(pass4), .err_count(err4), .fail_vec(fail4)
  );

  gate_vector_sequencer #(.HOLD_CYCLES(1), .TRUTH(4'b0001)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .y(y1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_vec(fail1)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Packs {a,b,busy,done,pass,err_count,fail_vec} into one status word.
  function automatic logic [15:0] st(input logic a, input logic b, input logic busy,
                                     input logic done, input logic pass,
                                     input logic [2:0] err, input logic [3:0] fail);
    return {4'd0, a, b, busy, done, pass, err, fail};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts both sequencers, checks the clear on the first cycle, tracks the
  // applied vector every busy cycle and the busy length of each.
  task automatic do_run(input string name, input bit repulse);
    int n4 = 0;
    int n1 = 0;
    bit ok4 = 1'b1;
    bit ok1 = 1'b1;
    start4 = 1'b1;
    start1 = 1'b1;
    step();
    start4 = 1'b0;
    start1 = 1'b0;
    check({name, "_clr4"}, st(a4, b4, busy4, done4, pass4, err4, fail4),
          st(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0));
    check({name, "_clr1"}, st(a1, b1, busy1, done1, pass1, err1, fail1),
          st(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0));
    for (int i = 0; i < 100 && (busy4 || busy1); i++) begin
      if (busy4) begin
        if ({a4, b4} != 2'(n4 / 4)) ok4 = 1'b0;
        n4++;
      end
      if (busy1) begin
        if ({a1, b1} != 2'(n1)) ok1 = 1'b0;
        n1++;
      end
      if (repulse && i == 5) start4 = 1'b1;
      step();
      start4 = 1'b0;
    end
    check({name, "_len4"}, 16'(n4), 16'd16);
    check({name, "_len1"}, 16'(n1), 16'd4);
    check({name, "_seq4"}, 16'(ok4), 16'd1);
    check({name, "_seq1"}, 16'(ok1), 16'd1);
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    step();
    step();
    check("rst4", st(a4, b4, busy4, done4, pass4, err4, fail4), 16'd0);
    check("rst1", st(a1, b1, busy1, done1, pass1, err1, fail1), 16'd0);
    rst = 1'b0;
    step();
    check("idle4", st(a4, b4, busy4, done4, pass4, err4, fail4), 16'd0);

    // NOR gate: clean pass
    mode = 0;
    do_run("nor", 1'b0);
    check("nor_res4", st(a4, b4, busy4, done4, pass4, err4, fail4),
          st(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 4'b0000));
    check("nor_res1", st(a1, b1, busy1, done1, pass1, err1, fail1),
          st(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 4'b0000));
    step();
    check("nor_hold4", st(a4, b4, busy4, done4, pass4, err4, fail4),
          st(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 4'b0000));

    // y stuck at 0, restarted straight from DONE
    mode = 1;
    do_run("y0", 1'b0);
    check("y0_res4", st(a4, b4, busy4, done4, pass4, err4, fail4),
          st(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 4'b0001));
    check("y0_res1", st(a1, b1, busy1, done1, pass1, err1, fail1),
          st(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 4'b0001));

    // OR gate: every vector wrong
    mode = 2;
    do_run("or", 1'b0);
    check("or_res4", st(a4, b4, busy4, done4, pass4, err4, fail4),
          st(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd4, 4'b1111));
    check("or_res1", st(a1, b1, busy1, done1, pass1, err1, fail1),
          st(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd4, 4'b1111));

    // start re-pulsed mid-run on the HOLD_CYCLES=4 unit is ignored
    mode = 0;
    do_run("rep", 1'b1);
    check("rep_res4", st(a4, b4, busy4, done4, pass4, err4, fail4),
          st(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 4'b0000));

    // Reset in the middle of vector 2 with y stuck at 0
    mode = 1;
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    begin
      int waited = 0;
      while (!({a4, b4} == 2'b10 && busy4) && waited < 40) begin
        step();
        waited++;
      end
      check("mid_reach", 16'(waited < 40), 16'd1);
    end
    check("mid_err", 16'(err4), 16'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst4", st(a4, b4, busy4, done4, pass4, err4, fail4), 16'd0);
    check("mid_rst1", st(a1, b1, busy1, done1, pass1, err1, fail1), 16'd0);
    step();
    check("mid_idle4", st(a4, b4, busy4, done4, pass4, err4, fail4), 16'd0);

    // Clean run after the reset
    mode = 0;
    do_run("post", 1'b0);
    check("post_res4", st(a4, b4, busy4, done4, pass4, err4, fail4),
          st(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 4'b0000));
    check("post_res1", st(a1, b1, busy1, done1, pass1, err1, fail1),
          st(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 4'b0000));

    // rst and start on the same edge: rst wins
    rst = 1'b1;
    start4 = 1'b1;
    step();
    rst = 1'b0;
    start4 = 1'b0;
    check("rst_start4", st(a4, b4, busy4, done4, pass4, err4, fail4), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gate_vector_sequencer.md
Name: gate_vector_sequencer

Overview:
- Self-checking stimulus and response stage for 2-input combinational gates.
- Drives the gate's a/b inputs through all four input vectors and samples the gate's y output.
- Compares each sample against a parameterised truth table and reports per-vector failures, an error count and pass/done flags.
- Sits directly upstream (feeds a, b) and downstream (consumes y) of the gate under test; the default truth table is NOR.

Parameters:
- HOLD_CYCLES, 4, clock cycles each vector is held before y is sampled; legal range 1..255.
- TRUTH, 4'b0001, expected y per vector; bit index = {a,b}; default is NOR (y=1 only for a=0,b=0).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to begin a run.
- a  output  1  gate input A (registered).
- b  output  1  gate input B (registered).
- y  input  1  gate output, combinational from a/b.
- busy  output  1  high while vectors are being applied.
- done  output  1  high after a run completes; held until the next accepted start or rst.
- pass  output  1  valid while done=1; 1 when err_count==0.
- err_count  output  3  number of mismatching vectors, 0..4.
- fail_vec  output  4  bit k set when vector k ({a,b}=k) mismatched.

Behaviour:
- Reset (rst=1 at a rising edge, any state including mid-run):
  - State goes to IDLE.
  - a=0, b=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0.
  - Hold counter and vector index cleared; no partial results retained.
- States: IDLE, RUN, DONE.
- IDLE:
  - a=b=0.
  - start=1 at an edge → RUN.
  - On that same edge: vec=0, hold=0, err_count=0, fail_vec=0, done=0, pass=0, busy=1.
- RUN:
  - {a,b}=vec is driven from registers.
  - hold increments each cycle.
  - On the edge where hold==HOLD_CYCLES-1, y is sampled.
  - Mismatch rule: y !== TRUTH[vec], so X/Z counts as a mismatch. On mismatch, fail_vec[vec] is set and err_count increments.
  - On the same edge, hold clears and vec increments, so the next vector is applied with zero dead cycles.
  - Vector order: 00, 01, 10, 11.
- End of run:
  - On the sample edge of vec=3 → DONE.
  - On that edge: busy=0, done=1, a=b=0, and pass is computed from the final err_count, including vec 3's result.
  - busy is high for exactly 4*HOLD_CYCLES cycles.
- DONE:
  - Results are stable.
  - start=1 → RUN with the same clearing as from IDLE; done drops the cycle busy rises.
- start while busy=1 is ignored; the run is not restarted.
- rst and start asserted on the same edge: rst wins.
- Latency: a/b change on the edge after start. The first y sample occurs HOLD_CYCLES edges after the vector appears, giving the gate HOLD_CYCLES cycles to settle.
- Width rules:
  - err_count saturates naturally at 4 (3 bits, no wrap).
  - Hold counter is 8 bits.
  - vec is 2 bits; its wrap after 3 is not used because the state leaves RUN.

Test Plan:
- NOR gate connected, HOLD_CYCLES=4, one start pulse → a/b sequence 00,01,10,11 each held 4 cycles; busy high 16 cycles; then done=1, pass=1, err_count=0, fail_vec=4'b0000, a=b=0.
- y tied to 0, TRUTH=4'b0001 → done=1, pass=0, err_count=1, fail_vec=4'b0001.
- OR gate connected (complement of NOR) → err_count=4, fail_vec=4'b1111, pass=0.
- HOLD_CYCLES=1, NOR gate → a/b change every cycle; busy high exactly 4 cycles; pass=1.
- rst pulsed during vec=2 with y forced 0 → next cycle all outputs 0 and state IDLE; a following start yields a clean full run with pass=1.
- start re-pulsed during RUN → ignored; run length stays 4*HOLD_CYCLES. start pulsed in DONE → done falls, busy rises, err_count and fail_vec cleared, new run completes.
